// File: rtl/run_length_decode_stage_if.sv
// Symbol-in / coefficient-pair-out bundle for the run-length decode stage.
// slave is the decoder side, master is the producer/consumer side.
interface run_length_decode_stage_if #(
  parameter int DATA_WIDTH   = 15,
  parameter int OUTPUT_WIDTH = 16
);
  logic [OUTPUT_WIDTH-1:0] i_data0;
  logic [OUTPUT_WIDTH-1:0] i_data1;
  logic                    wen;
  logic                    o_ready;
  logic [DATA_WIDTH-1:0]   o_data0;
  logic [DATA_WIDTH-1:0]   o_data1;
  logic                    rsync;
  logic                    o_last;
  logic                    o_err;

  modport slave (
    input  i_data0, i_data1, wen,
    output o_ready, o_data0, o_data1, rsync, o_last, o_err
  );

  modport master (
    output i_data0, i_data1, wen,
    input  o_ready, o_data0, o_data1, rsync, o_last, o_err
  );
endinterface

// File: rtl/run_length_decode_stage.sv
// Expands (run, value) symbols into 64-coefficient blocks, emitting one
// even/odd coefficient pair per rsync beat.
module run_length_decode_stage #(
  parameter int DATA_WIDTH   = 15,
  parameter int OUTPUT_WIDTH = 16
) (
  input  logic                           i_clk,
  input  logic                           i_resetn,
  run_length_decode_stage_if.slave       bus
);

  localparam int RunW = OUTPUT_WIDTH + 1;
  localparam logic [6:0] BlockLen = 7'd64;

  typedef enum logic {StAccept, StExpand} state_e;

  state_e                r_state;
  logic                  r_ready;
  logic [6:0]            r_pos;
  logic [6:0]            r_rem;
  logic [DATA_WIDTH-1:0] r_val;
  logic                  r_has_val;
  logic                  r_ovf;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [DATA_WIDTH-1:0] r_data0;
  logic [DATA_WIDTH-1:0] r_data1;
  logic                  r_rsync;
  logic                  r_last;
  logic                  r_err;

  logic [6:0]            w_room;
  logic [RunW-1:0]       w_run_p1;
  logic                  w_eob;
  logic                  w_ovf;
  logic [1:0]            w_k;
  logic [DATA_WIDTH-1:0] w_slot0;
  logic [DATA_WIDTH-1:0] w_slot1;
  logic [6:0]            w_pos_nx;
  logic [6:0]            w_rem_nx;
  logic                  w_unused;

  assign w_room   = BlockLen - r_pos;
  assign w_run_p1 = {1'b0, bus.i_data0} + RunW'(1);
  assign w_eob    = &bus.i_data0;
  assign w_ovf    = !w_eob && (w_run_p1 > RunW'(w_room));
  assign w_unused = ^bus.i_data1[OUTPUT_WIDTH-1:DATA_WIDTH];

  // The symbol's value is its last coefficient, i.e. the one generated when r_rem counts down to 1.
  always_comb begin
    w_k     = 2'd2;
    w_slot0 = r_buf0;
    w_slot1 = r_buf1;
    if (r_pos[0]) begin
      w_k     = 2'd1;
      w_slot1 = (r_rem == 7'd1 && r_has_val) ? r_val : '0;
    end else if (r_rem == 7'd1) begin
      w_k     = 2'd1;
      w_slot0 = r_has_val ? r_val : '0;
    end else begin
      w_slot0 = '0;
      w_slot1 = (r_rem == 7'd2 && r_has_val) ? r_val : '0;
    end
  end

  assign w_pos_nx = r_pos + {5'd0, w_k};
  assign w_rem_nx = r_rem - {5'd0, w_k};

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state   <= StAccept;
      r_ready   <= 1'b1;
      r_pos     <= '0;
      r_rem     <= '0;
      r_val     <= '0;
      r_has_val <= 1'b0;
      r_ovf     <= 1'b0;
      r_buf0    <= '0;
      r_buf1    <= '0;
      r_data0   <= '0;
      r_data1   <= '0;
      r_rsync   <= 1'b0;
      r_last    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rsync <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      unique case (r_state)
        StAccept: begin
          if (bus.wen) begin
            // EOB and overflowing symbols both pad with zeros to the end of the block.
            r_rem     <= (w_eob || w_ovf) ? w_room : w_run_p1[6:0];
            r_has_val <= !w_eob && !w_ovf;
            r_ovf     <= w_ovf;
            r_val     <= bus.i_data1[DATA_WIDTH-1:0];
            r_state   <= StExpand;
            r_ready   <= 1'b0;
          end
        end
        StExpand: begin
          r_buf0 <= w_slot0;
          r_buf1 <= w_slot1;
          r_rem  <= w_rem_nx;
          r_pos  <= w_pos_nx;
          if (!w_pos_nx[0]) begin
            r_data0 <= w_slot0;
            r_data1 <= w_slot1;
            r_rsync <= 1'b1;
          end
          if (w_pos_nx == BlockLen) begin
            r_last <= 1'b1;
            r_err  <= r_ovf;
            r_pos  <= '0;
          end
          if (w_rem_nx == 7'd0 || w_pos_nx == BlockLen) begin
            r_state <= StAccept;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= StAccept;
      endcase
    end
  end

  assign bus.o_ready = r_ready;
  assign bus.o_data0 = r_data0;
  assign bus.o_data1 = r_data1;
  assign bus.rsync   = r_rsync;
  assign bus.o_last  = r_last;
  assign bus.o_err   = r_err;

endmodule

// File: tb/tb_run_length_decode_stage.sv
// Scoreboard bench for run_length_decode_stage: stimulus queues expected
// beats, an independent monitor pops and compares them on every rsync.
module tb_run_length_decode_stage;

  localparam int DW = 15;
  localparam int OW = 16;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  run_length_decode_stage_if #(.DATA_WIDTH(DW), .OUTPUT_WIDTH(OW)) bus ();

  run_length_decode_stage #(.DATA_WIDTH(DW), .OUTPUT_WIDTH(OW)) dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .bus      (bus)
  );

  typedef struct packed {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          last;
    logic          err;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fails = 0;
  int    n_beats = 0;

  // Status checks requested by stimulus, executed by the monitor.
  int          chk_seq = 0;
  int          mon_seq = 0;
  string       chk_name;
  logic [33:0] chk_exp;
  logic [33:0] chk_mask;
  logic [33:0] status;
  assign status = {bus.o_ready, bus.rsync, bus.o_last, bus.o_err, bus.o_data0, bus.o_data1};

  always @(negedge clk) begin
    beat_t got;
    beat_t e;
    if (resetn && bus.rsync) begin
      n_beats++;
      got = {bus.o_data0, bus.o_data1, bus.o_last, bus.o_err};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_beat: got %h required no beat", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fails++;
          $display("FAIL beat%0d: got d0=%h d1=%h last=%b err=%b required d0=%h d1=%h last=%b err=%b",
                   n_beats, got.d0, got.d1, got.last, got.err, e.d0, e.d1, e.last, e.err);
        end
      end
    end
    if (!bus.rsync && (bus.o_last || bus.o_err)) begin
      n_tests++;
      n_fails++;
      $display("FAIL stray_pulse: got last=%b err=%b required 0 without rsync", bus.o_last, bus.o_err);
    end
    if (chk_seq != mon_seq) begin
      mon_seq = chk_seq;
      n_tests++;
      if ((status & chk_mask) !== (chk_exp & chk_mask)) begin
        n_fails++;
        $display("FAIL %s: got %h required %h (mask %h)", chk_name, status, chk_exp, chk_mask);
      end
    end
  end

  task automatic push(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic last, input logic err);
    exp_q.push_back({d0, d1, last, err});
  endtask

  // n zero pairs ending the block; err marks an overflowed block.
  task automatic push_zeros(input int n, input logic err);
    for (int i = 0; i < n; i++) push('0, '0, i == n - 1, (i == n - 1) && err);
  endtask

  task automatic check(input string name, input logic [33:0] exp, input logic [33:0] mask);
    @(posedge clk);
    #1;
    chk_name = name;
    chk_exp  = exp;
    chk_mask = mask;
    chk_seq++;
    @(negedge clk);
    #1;
  endtask

  // poke holds wen high with a junk symbol for one busy cycle; it must be ignored.
  task automatic send(input logic [OW-1:0] run, input logic [OW-1:0] val, input bit poke);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.o_ready) begin
      t++;
      if (t > 300) begin
        $display("FAIL send_timeout: got o_ready=0 required 1 within 300 cycles");
        $fatal(1, "timeout");
      end
      @(negedge clk);
    end
    bus.i_data0 = run;
    bus.i_data1 = val;
    bus.wen     = 1'b1;
    @(negedge clk);
    if (poke) begin
      bus.i_data0 = 16'd0;
      bus.i_data1 = 16'h1234;
      @(negedge clk);
    end
    bus.wen = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 || !bus.o_ready) begin
      @(negedge clk);
      t++;
      if (t > 400) begin
        $display("FAIL drain_timeout: got %0d beats pending required 0", exp_q.size());
        $fatal(1, "timeout");
      end
    end
    repeat (2) @(negedge clk);
  endtask

  localparam logic [33:0] MaskAll   = '1;
  localparam logic [33:0] MaskReady = {1'b1, 33'd0};
  localparam logic [33:0] IdleZero  = {1'b1, 3'b000, 30'd0};

  initial begin
    int base;
    int t;
    bus.wen     = 1'b0;
    bus.i_data0 = '0;
    bus.i_data1 = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    check("reset_state", IdleZero, MaskAll);

    // Lone EOB at pos 0: 32 zero pairs.
    push_zeros(32, 1'b0);
    send(16'hFFFF, 16'd0, 1'b0);
    check("eob_busy", 34'd0, MaskReady);
    drain();
    check("eob_idle_after", IdleZero, MaskAll);

    // Two single values fill one pair; negative value truncated to DW bits.
    push(15'd5, 15'h7FFD, 1'b0, 1'b0);
    push_zeros(31, 1'b0);
    send(16'd0, 16'd5, 1'b0);
    send(16'd0, 16'hFFFD, 1'b1);
    send(16'hFFFF, 16'd0, 1'b0);
    drain();

    // Half-filled pair waits for the next symbol.
    push(15'd0, 15'd7, 1'b0, 1'b0);
    push(15'd0, 15'd0, 1'b0, 1'b0);
    push(15'd4, 15'd6, 1'b0, 1'b0);
    push_zeros(29, 1'b0);
    send(16'd1, 16'd7, 1'b0);
    send(16'd2, 16'd4, 1'b1);
    repeat (6) @(negedge clk);
    check("pair_pending_hold", IdleZero, MaskAll);
    send(16'd0, 16'd6, 1'b0);
    send(16'hFFFF, 16'd0, 1'b0);
    drain();

    // Overflow: value 9 dropped, err with last.
    push(15'd1, 15'd0, 1'b0, 1'b0);
    push_zeros(31, 1'b1);
    send(16'd0, 16'd1, 1'b0);
    send(16'd63, 16'd9, 1'b0);
    drain();

    // Reset mid-block discards the rest.
    push_zeros(32, 1'b0);
    base = n_beats;
    send(16'hFFFF, 16'd0, 1'b0);
    t = 0;
    while (n_beats < base + 10) begin
      @(negedge clk);
      t++;
      if (t > 100) begin
        $display("FAIL beat_timeout: got %0d beats required 10", n_beats - base);
        $fatal(1, "timeout");
      end
    end
    resetn = 1'b0;
    exp_q.delete();
    check("reset_mid_block", IdleZero, MaskAll);
    @(negedge clk);
    resetn = 1'b1;
    check("after_abort_idle", IdleZero, MaskAll);
    push(15'd3, 15'd0, 1'b0, 1'b0);
    push_zeros(31, 1'b0);
    send(16'd0, 16'd3, 1'b0);
    send(16'hFFFF, 16'd0, 1'b0);
    drain();
    check("final_idle", IdleZero, MaskAll);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
